// File: rtl/trigger_capture_fifo.sv
// trigger_capture_fifo: serial trigger-ID decoder with timestamped event FIFO and diagnostic counters
module trigger_capture_fifo #(
  parameter int ID_WIDTH    = 16,
  parameter int CYCLE_WIDTH = 64,
  parameter int FIFO_DEPTH  = 8,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int TIMEOUT     = 1024,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                               sampling_clk,
  input  logic                               reset_n,
  input  logic                               trig_in_rising,
  input  logic                               trig_id_sync,
  input  logic                               clk_in_falling,
  input  logic [CYCLE_WIDTH-1:0]             cycle,
  input  logic                               clear_counters,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [ID_WIDTH-1:0]                out_id,
  output logic [CYCLE_WIDTH-1:0]             out_cycle,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               interrupt,
  output logic                               busy,
  output logic                               overflow,
  output logic [CNT_WIDTH-1:0]               drop_count,
  output logic [CNT_WIDTH-1:0]               veto_count,
  output logic [CNT_WIDTH-1:0]               timeout_count
);
  localparam int LW = $clog2(FIFO_DEPTH+1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(ID_WIDTH+1);
  localparam int TW = $clog2(TIMEOUT+1);

  typedef enum logic {IDLE, CAPTURE} state_t;

  state_t                 state_q, state_d;
  logic [ID_WIDTH-1:0]    shift_q, shift_d;
  logic [BW-1:0]          bits_q, bits_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic [CYCLE_WIDTH-1:0] ts_q, ts_d;
  logic                   push_q, push_d;
  logic                   veto_inc, tmo_inc;

  logic [ID_WIDTH-1:0]    id_mem [FIFO_DEPTH];
  logic [CYCLE_WIDTH-1:0] cyc_mem [FIFO_DEPTH];
  logic [PW-1:0]          wr_q, rd_q;
  logic [LW-1:0]          level_q;
  logic                   full, pop, push_ok, drop;
  logic                   interrupt_q, overflow_q;
  logic [CNT_WIDTH-1:0]   drop_q, veto_q, tmo_cnt_q;

  function automatic logic [CNT_WIDTH-1:0] bump(input logic [CNT_WIDTH-1:0] c, input logic inc);
    return (inc && c != '1) ? c + CNT_WIDTH'(1) : c;
  endfunction

  // Capture state and shift/timestamp registers
  always_ff @(posedge sampling_clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      bits_q  <= '0;
      tmo_q   <= '0;
      ts_q    <= '0;
      push_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bits_q  <= bits_d;
      tmo_q   <= tmo_d;
      ts_q    <= ts_d;
      push_q  <= push_d;
    end

  // Next-state: start on a trigger, shift bits on clk_in falling edges, abort on stall
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bits_d   = bits_q;
    tmo_d    = tmo_q;
    ts_d     = ts_q;
    push_d   = 1'b0;
    veto_inc = 1'b0;
    tmo_inc  = 1'b0;
    if (state_q == IDLE) begin
      if (trig_in_rising) begin
        state_d = CAPTURE;
        shift_d = '0;
        bits_d  = '0;
        tmo_d   = '0;
        ts_d    = cycle;
      end
    end else begin
      veto_inc = trig_in_rising;
      if (clk_in_falling) begin
        shift_d = MSB_FIRST ? {shift_q[ID_WIDTH-2:0], trig_id_sync} : {trig_id_sync, shift_q[ID_WIDTH-1:1]};
        bits_d  = bits_q + BW'(1);
        tmo_d   = '0;
        if (bits_q == BW'(ID_WIDTH-1)) begin
          state_d = IDLE;
          push_d  = 1'b1;
        end
      end else begin
        tmo_d = tmo_q + TW'(1);
        if (tmo_q == TW'(TIMEOUT-1)) begin
          state_d = IDLE;
          tmo_inc = 1'b1;
        end
      end
    end
  end

  // The assembled ID and timestamp stay put in IDLE, so the push one cycle later reads them directly
  assign full    = level_q == LW'(FIFO_DEPTH);
  assign pop     = out_valid & out_ready;
  assign push_ok = push_q & (~full | pop);
  assign drop    = push_q & ~push_ok;

  // Event storage; no reset needed since the head is masked while empty
  always_ff @(posedge sampling_clk)
    if (push_ok) begin
      id_mem[wr_q]  <= shift_q;
      cyc_mem[wr_q] <= ts_q;
    end

  // FIFO pointers, occupancy and push interrupt
  always_ff @(posedge sampling_clk or negedge reset_n)
    if (!reset_n) begin
      wr_q        <= '0;
      rd_q        <= '0;
      level_q     <= '0;
      interrupt_q <= 1'b0;
    end else begin
      wr_q        <= wr_q + PW'(push_ok);
      rd_q        <= rd_q + PW'(pop);
      level_q     <= level_q + LW'(push_ok) - LW'(pop);
      interrupt_q <= push_ok;
    end

  // Saturating diagnostics; clear wins over a same-cycle increment
  always_ff @(posedge sampling_clk or negedge reset_n)
    if (!reset_n) begin
      drop_q     <= '0;
      veto_q     <= '0;
      tmo_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      drop_q     <= clear_counters ? '0 : bump(drop_q, drop);
      veto_q     <= clear_counters ? '0 : bump(veto_q, veto_inc);
      tmo_cnt_q  <= clear_counters ? '0 : bump(tmo_cnt_q, tmo_inc);
      overflow_q <= clear_counters ? 1'b0 : (overflow_q | drop);
    end

  assign out_valid     = level_q != '0;
  assign out_id        = out_valid ? id_mem[rd_q] : '0;
  assign out_cycle     = out_valid ? cyc_mem[rd_q] : '0;
  assign fifo_level    = level_q;
  assign interrupt     = interrupt_q;
  assign busy          = state_q == CAPTURE;
  assign overflow      = overflow_q;
  assign drop_count    = drop_q;
  assign veto_count    = veto_q;
  assign timeout_count = tmo_cnt_q;
endmodule

// File: doc/trigger_capture_fifo.md
Name: trigger_capture_fifo

Overview:
- Parametrised successor to the single-event trigger decoder.
- Decodes a serial trigger ID of configurable width and bit order, and timestamps each trigger with the reference cycle count.
- Queues completed events in a FIFO with a valid/ready output; handles overlapping triggers, stalled ID clocks and FIFO overflow with counters.
- Sits between the sync/clk_ref stage, which supplies pre-synchronised edge pulses and the cycle count, and the readout/interrupt logic.

Parameters:
- ID_WIDTH, 16: number of serial ID bits per trigger (2..32).
- CYCLE_WIDTH, 64: width of the cycle timestamp.
- FIFO_DEPTH, 8: event FIFO entries; power of two, 2..64.
- MSB_FIRST, 1: 1 = first received bit lands in the ID MSB (shift left); 0 = first bit lands in the LSB (shift right).
- TIMEOUT, 1024: sampling_clk cycles without clk_in_falling during capture before the capture is aborted.
- CNT_WIDTH, 16: width of the saturating diagnostic counters.

Ports:
- sampling_clk  in  1  sole clock
- reset_n  in  1  asynchronous active-low reset
- trig_in_rising  in  1  one-cycle pulse, synchronised trig_in rising edge
- trig_id_sync  in  1  synchronised serial ID bit
- clk_in_falling  in  1  one-cycle pulse, synchronised clk_in falling edge
- cycle  in  CYCLE_WIDTH  current reference cycle count
- clear_counters  in  1  synchronous pulse; zeroes all diagnostic counters and the overflow flag
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts the head
- out_id  out  ID_WIDTH  head trigger ID
- out_cycle  out  CYCLE_WIDTH  head timestamp
- fifo_level  out  clog2(FIFO_DEPTH+1)  number of occupied entries
- interrupt  out  1  one-cycle pulse on every successful FIFO push
- busy  out  1  high while in CAPTURE
- overflow  out  1  sticky; set on any dropped event
- drop_count  out  CNT_WIDTH  events dropped because the FIFO was full
- veto_count  out  CNT_WIDTH  trig_in_rising pulses ignored while busy
- timeout_count  out  CNT_WIDTH  captures aborted by timeout

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = IDLE.
  - Shift register, bit counter, timeout counter, FIFO pointers and fifo_level = 0.
  - out_valid = 0, interrupt = 0, busy = 0, overflow = 0, all counters = 0.
  - out_id and out_cycle = 0.
  - Reset mid-capture discards the partial event; FIFO contents are lost.
- IDLE:
  - On trig_in_rising: go to CAPTURE next cycle; clear shift register and bit counter; latch cycle (the value present on the pulse cycle) as the event timestamp; clear the timeout counter.
  - clk_in_falling in the same cycle as trig_in_rising is not sampled as an ID bit.
- CAPTURE:
  - busy = 1.
  - On clk_in_falling: shift in trig_id_sync per MSB_FIRST; increment the bit counter; clear the timeout counter.
  - When the ID_WIDTH-th bit is shifted in, a push request for {assembled ID, latched timestamp} is issued in the following cycle and the state returns to IDLE.
  - Cycles without clk_in_falling increment the timeout counter. When it reaches TIMEOUT: abort, timeout_count += 1, return to IDLE, no push.
  - trig_in_rising while in CAPTURE (including the completion cycle): ignored; veto_count += 1.
- FIFO:
  - A push succeeds if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the event is dropped: drop_count += 1 and overflow = 1.
  - Pop occurs when out_valid & out_ready.
  - out_id/out_cycle show the head combinationally from storage; they are stable while out_valid & !out_ready.
  - A push into an empty FIFO raises out_valid on the next cycle.
  - fifo_level is updated the same edge as the pointers; simultaneous push and pop leave the level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- interrupt pulses for exactly one cycle, registered with the successful push.
- Counters saturate at 2^CNT_WIDTH-1.
- clear_counters has priority over a same-cycle increment: the result is 0.

Test Plan:
- Basic capture, MSB_FIRST=1: trig_in_rising with cycle=100, then 16 clk_in_falling pulses with bits 0xA5C3 MSB first -> one push; out_id=0xA5C3, out_cycle=100, interrupt pulses once, fifo_level=1.
- Bit order, MSB_FIRST=0, ID_WIDTH=8: serial bits 1,0,0,0,0,0,0,0 -> out_id=0x01.
- Overflow, FIFO_DEPTH=4, out_ready=0: six complete triggers -> fifo_level=4, drop_count=2, overflow=1. Then hold out_ready high -> entries 1..4 pop in order; overflow stays 1 until clear_counters.
- Veto and timeout, TIMEOUT=50: second trig_in_rising after 5 bits -> veto_count=1 and capture continues. Then stop clk_in -> after 50 idle cycles busy drops, timeout_count=1, no push.
- Full FIFO with simultaneous pop and push -> push accepted, level stays FIFO_DEPTH, drop_count unchanged.
- Reset mid-capture after 7 bits with 2 FIFO entries -> all outputs at reset values. A following full trigger is captured correctly.
